// File: rtl/lcd_win_ctrl.sv
// LCD window controller: loads an IMG_W x IMG_H frame and emits WIN x WIN fit/zoom views.
// Optional horizontal mirror command (cmd 7) is compiled in with LCD_MIRROR_EN.
module lcd_win_ctrl #(
  parameter int IMG_W = 12,
  parameter int IMG_H = 9,
  parameter int DW    = 8,
  parameter int WIN   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);

  localparam logic [AW-1:0] W_A    = AW'(IMG_W);
  localparam logic [AW-1:0] HALF   = AW'(WIN / 2);
  localparam logic [AW-1:0] CX_DEF = AW'(IMG_W / 2);
  localparam logic [AW-1:0] CY_DEF = AW'(IMG_H / 2);
  localparam logic [AW-1:0] CX_MAX = AW'(IMG_W - WIN / 2);
  localparam logic [AW-1:0] CY_MAX = AW'(IMG_H - WIN / 2);
  localparam logic [AW-1:0] SX_A   = AW'(IMG_W / WIN);
  localparam logic [AW-1:0] SY_A   = AW'(IMG_H / WIN);
  localparam logic [AW-1:0] SX_H   = AW'((IMG_W / WIN) / 2);
  localparam logic [AW-1:0] SY_H   = AW'((IMG_H / WIN) / 2);
  localparam logic [AW-1:0] LAST   = AW'(WIN - 1);
  localparam logic [AW-1:0] N_LAST = AW'(N - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [2:0] CMD_LOAD     = 3'd0;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd1;
  localparam logic [2:0] CMD_ZOOM_FIT = 3'd2;
  localparam logic [2:0] CMD_RIGHT    = 3'd3;
  localparam logic [2:0] CMD_LEFT     = 3'd4;
  localparam logic [2:0] CMD_UP       = 3'd5;
  localparam logic [2:0] CMD_DOWN     = 3'd6;
  localparam logic [2:0] CMD_MIRROR   = 3'd7;

  logic [1:0]    state;
  logic          zoom;
  logic          mirror;
  logic [2:0]    shift_cmd;
  logic [AW-1:0] cx, cy;
  logic [AW-1:0] load_cnt;
  logic [AW-1:0] out_r, out_c;
  logic [AW-1:0] col_eff, row_addr, col_addr, addr;
  logic [DW-1:0] pix_buf [N];

  // Handshake: a command is taken on a rising edge with cmd_valid=1 while busy=0;
  // busy rises the next cycle and stays high until the operation's last output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      zoom      <= 1'b0;
      mirror    <= 1'b0;
      shift_cmd <= CMD_LOAD;
      cx        <= CX_DEF;
      cy        <= CY_DEF;
      load_cnt  <= '0;
      out_r     <= '0;
      out_c     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          out_r <= '0;
          out_c <= '0;
          if (cmd_valid) begin
            case (cmd)
              CMD_LOAD: begin
                load_cnt <= '0;
                state    <= ST_LOAD;
              end
              CMD_ZOOM_IN: begin
                zoom  <= 1'b1;
                state <= ST_OUT;
              end
              CMD_ZOOM_FIT: begin
                zoom  <= 1'b0;
                cx    <= CX_DEF;
                cy    <= CY_DEF;
                state <= ST_OUT;
              end
              CMD_MIRROR: begin
`ifdef LCD_MIRROR_EN
                mirror <= ~mirror;
                state  <= ST_OUT;
`endif
              end
              default: begin
                shift_cmd <= cmd;
                state     <= ST_SHIFT;
              end
            endcase
          end
        end
        ST_LOAD: begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == N_LAST) begin
            zoom   <= 1'b0;
            mirror <= 1'b0;
            cx     <= CX_DEF;
            cy     <= CY_DEF;
            state  <= ST_OUT;
          end
        end
        ST_SHIFT: begin
          // Center only moves in zoom mode; fit mode just re-emits the fit view.
          if (zoom) begin
            case (shift_cmd)
              CMD_RIGHT: if (cx < CX_MAX) cx <= cx + 1'b1;
              CMD_LEFT:  if (cx > HALF)   cx <= cx - 1'b1;
              CMD_UP:    if (cy > HALF)   cy <= cy - 1'b1;
              CMD_DOWN:  if (cy < CY_MAX) cy <= cy + 1'b1;
              default: ;
            endcase
          end
          state <= ST_OUT;
        end
        default: begin
          if (out_c == LAST) begin
            out_c <= '0;
            if (out_r == LAST) state <= ST_IDLE;
            else               out_r <= out_r + 1'b1;
          end else begin
            out_c <= out_c + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_LOAD) pix_buf[load_cnt] <= datain;
  end

  always_comb begin
    col_eff  = mirror ? (LAST - out_c) : out_c;
    row_addr = zoom ? (cy - HALF + out_r)   : (SY_H + SY_A * out_r);
    col_addr = zoom ? (cx - HALF + col_eff) : (SX_H + SX_A * col_eff);
    addr     = row_addr * W_A + col_addr;
  end

  assign dataout      = (state == ST_OUT) ? pix_buf[addr] : '0;
  assign output_valid = (state == ST_OUT);
  assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Randomized bench for lcd_win_ctrl against a view-level reference model.
module tb_lcd_win_ctrl;
  localparam int IMG_W = 12;
  localparam int IMG_H = 9;
  localparam int DW    = 8;
  localparam int WIN   = 4;
  localparam int N     = IMG_W * IMG_H;
  localparam int NP    = WIN * WIN;
  localparam int SX    = IMG_W / WIN;
  localparam int SY    = IMG_H / WIN;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] datain;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  lcd_win_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] buf_m [N];
  logic [DW-1:0] exp_q [$];
  bit            zoom_m, mirror_m;
  int            cx_m, cy_m;
  int            last_out [NP];

  int fit_kat  [NP] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
  int zoom_kat [NP] = '{28, 29, 30, 31, 40, 41, 42, 43, 52, 53, 54, 55, 64, 65, 66, 67};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    zoom_m   = 1'b0;
    mirror_m = 1'b0;
    cx_m     = IMG_W / 2;
    cy_m     = IMG_H / 2;
  endtask

  // Builds the expected WIN x WIN view from the current model state.
  task automatic build_view();
    int cc;
    exp_q.delete();
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++) begin
        cc = mirror_m ? (WIN - 1 - c) : c;
        if (zoom_m) exp_q.push_back(buf_m[(cy_m - WIN/2 + r) * IMG_W + cx_m - WIN/2 + cc]);
        else        exp_q.push_back(buf_m[(SY/2 + SY*r) * IMG_W + SX/2 + SX*cc]);
      end
  endtask

  task automatic collect(input string tag, input int abort_at);
    int budget = 6;
    logic [DW-1:0] e;
    build_view();
    while (!output_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!output_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < NP; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check({tag, "_rst_valid"}, output_valid, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_data"}, dataout, 0);
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0;
        model_reset();
        return;
      end
      e = exp_q.pop_front();
      check($sformatf("%s_px%0d", tag, k), dataout, e);
      check($sformatf("%s_ov%0d", tag, k), output_valid, 1);
      last_out[k] = dataout;
      // Commands offered while busy must be dropped.
      cmd       = 3'($urandom_range(0, 7));
      cmd_valid = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check({tag, "_end_valid"}, output_valid, 0);
    check({tag, "_end_busy"}, busy, 0);
  endtask

  task automatic do_load(input bit use_index);
    @(negedge clk);
    cmd = 3'd0;
    cmd_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (i == 0) check("load_busy", busy, 1);
      datain = use_index ? DW'(i) : DW'($urandom_range(0, (1 << DW) - 1));
      buf_m[i] = datain;
    end
    model_reset();
    collect("load", -1);
  endtask

  task automatic send_cmd(input logic [2:0] c);
    @(negedge clk);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] c);
    if (c == 3'd0) begin
      do_load(1'b0);
      return;
    end
`ifndef LCD_MIRROR_EN
    if (c == 3'd7) begin
      send_cmd(c);
      check("mir_off_busy", busy, 0);
      check("mir_off_valid", output_valid, 0);
      @(negedge clk);
      check("mir_off_busy2", busy, 0);
      return;
    end
`endif
    case (c)
      3'd1: zoom_m = 1'b1;
      3'd2: begin zoom_m = 1'b0; cx_m = IMG_W / 2; cy_m = IMG_H / 2; end
      3'd3: if (zoom_m) cx_m = (cx_m + 1 > IMG_W - WIN/2) ? IMG_W - WIN/2 : cx_m + 1;
      3'd4: if (zoom_m) cx_m = (cx_m - 1 < WIN/2) ? WIN/2 : cx_m - 1;
      3'd5: if (zoom_m) cy_m = (cy_m - 1 < WIN/2) ? WIN/2 : cy_m - 1;
      3'd6: if (zoom_m) cy_m = (cy_m + 1 > IMG_H - WIN/2) ? IMG_H - WIN/2 : cy_m + 1;
      default: mirror_m = ~mirror_m;
    endcase
    send_cmd(c);
    collect($sformatf("cmd%0d", c), -1);
  endtask

  initial begin
    reset = 1'b1;
    datain = '0;
    cmd = '0;
    cmd_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", output_valid, 0);
    check("rst_data", dataout, 0);
    reset = 1'b0;

    do_load(1'b1);
    for (int k = 0; k < NP; k++) check($sformatf("kat_fit%0d", k), last_out[k], fit_kat[k]);

    do_cmd(3'd1);
    for (int k = 0; k < NP; k++) check($sformatf("kat_zoom%0d", k), last_out[k], zoom_kat[k]);

    repeat (6) do_cmd(3'd3);
    for (int k = 0; k < 4; k++) check($sformatf("kat_sat%0d", k), last_out[k], 32 + k);
    do_cmd(3'd3);
    for (int k = 0; k < 4; k++) check($sformatf("kat_sat_again%0d", k), last_out[k], 32 + k);

    do_cmd(3'd2);
    do_cmd(3'd3);
    for (int k = 0; k < NP; k++) check($sformatf("kat_fitshift%0d", k), last_out[k], fit_kat[k]);

    do_cmd(3'd1);
    do_cmd(3'd7);
`ifdef LCD_MIRROR_EN
    for (int k = 0; k < 4; k++) check($sformatf("kat_mirror%0d", k), last_out[k], 31 - k);
`endif

    send_cmd(3'd1);
    collect("abort", 4);
    do_cmd(3'd1);
    for (int k = 0; k < NP; k++) check($sformatf("kat_retain%0d", k), last_out[k], zoom_kat[k]);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) do_cmd(3'd0);
      else                           do_cmd(3'($urandom_range(1, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_win_ctrl.md
LCD_WIN_CTRL -- requirements
Module: lcd_win_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 12, image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 9, image height in pixels.
REQ-003 SHALL have parameter DW, default 8, pixel width in bits.
REQ-004 SHALL have parameter WIN, default 4, output window edge (even, 2..min(IMG_W,IMG_H)).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port datain  input  DW  load pixel.
REQ-008 SHALL have port cmd  input  3  command code.
REQ-009 SHALL have port cmd_valid  input  1  command strobe.
REQ-010 SHALL have port dataout  output  DW  window pixel.
REQ-011 SHALL have port output_valid  output  1  dataout qualifier.
REQ-012 SHALL have port busy  output  1  command not accepted while high.

Function
REQ-013 SHALL accept cmd only on a rising edge with cmd_valid=1 and busy=0; busy SHALL be 1 from the following cycle until the operation ends.
REQ-014 SHALL decode cmd: 0 LOAD, 1 ZOOM_IN, 2 ZOOM_FIT, 3 RIGHT, 4 LEFT, 5 UP, 6 DOWN, 7 MIRROR (see Configuration).
REQ-015 SHALL implement FSM IDLE -> LOAD | SHIFT -> OUT -> IDLE; OUT is entered directly for ZOOM_IN/ZOOM_FIT.
REQ-016 LOAD SHALL capture datain on the N=IMG_W*IMG_H edges following acceptance, raster order (index = row*IMG_W+col), then enter OUT in fit mode with center reset.
REQ-017 OUT SHALL drive WIN*WIN pixels on consecutive cycles, row-major, with output_valid=1; busy and output_valid SHALL drop together on the cycle after the last pixel.
REQ-018 Fit mode pixel (r,c) SHALL be buffer[(SY/2+SY*r)*IMG_W + SX/2+SX*c], SX=IMG_W/WIN, SY=IMG_H/WIN (integer division).
REQ-019 Zoom mode pixel (r,c) SHALL be buffer[(cy-WIN/2+r)*IMG_W + cx-WIN/2+c].
REQ-020 Center SHALL default to (cx,cy)=(IMG_W/2, IMG_H/2) and be clamped to cx in [WIN/2, IMG_W-WIN/2], cy in [WIN/2, IMG_H-WIN/2].
REQ-021 ZOOM_IN SHALL enter zoom mode, center unchanged; ZOOM_FIT SHALL enter fit mode and restore the default center.
REQ-022 A shift in zoom mode SHALL move the center by 1 (RIGHT cx+1, LEFT cx-1, UP cy-1, DOWN cy+1), saturating at bounds, then output; a shift in fit mode SHALL leave the center unchanged and output the fit view.
REQ-023 Address arithmetic SHALL use width $clog2(IMG_W*IMG_H) with no truncation.
REQ-024 cmd_valid while busy=1 SHALL be ignored with no state change.

Reset
REQ-025 Reset SHALL force IDLE, busy=0, output_valid=0, dataout=0, fit mode, default center, mirror flag 0; pixel buffer is not reset.
REQ-026 Reset during LOAD or OUT SHALL abort immediately; output_valid SHALL be 0 while reset is high.

Configuration
REQ-027 With LCD_MIRROR_EN defined, cmd 7 SHALL toggle a horizontal-mirror flag and output the current view with columns emitted in reverse (c -> WIN-1-c); LOAD SHALL clear the flag.
REQ-028 Without LCD_MIRROR_EN, cmd 7 SHALL be ignored: busy stays 0, no output, no state change.

Verification
REQ-029 Reset, LOAD of pixel value = index 0..107 -> 16 outputs 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94; busy low next cycle.
REQ-030 ZOOM_IN after load -> 28,29,30,31,40,41,42,43,52,53,54,55,64,65,66,67.
REQ-031 ZOOM_IN then 6x RIGHT -> last output begins 32,33,34,35 (cx saturated at 10); one further RIGHT -> identical sequence.
REQ-032 RIGHT in fit mode -> same 16 values as REQ-029; cmd_valid pulses while busy=1 -> no effect.
REQ-033 LCD_MIRROR_EN, ZOOM_IN then cmd 7 -> 31,30,29,28,43,42,41,40,...; without macro cmd 7 -> busy stays 0.
REQ-034 Assert reset at 5th output cycle -> output_valid=0 and busy=0 immediately; a subsequent ZOOM_IN outputs 28,29,... (buffer retained).
